// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, hold and flush, with flush taking priority.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // Next IF/ID contents; a flush keeps pc/pc4 so later stages can still see where the bubble came from.
    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else if (stall_i) begin
            ifid_d = ifid_q;
        end else if (load_i) begin
            ifid_d = '{valid: 1'b1, pc: pc_i, pc4: pc4_i, instr: instr_i};
        end else begin
            ifid_d.valid = 1'b0;
        end
    end

    // IF/ID state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_q <= '{valid: 1'b0, pc: 32'h0000_0000, pc4: 32'h0000_0000, instr: NOP_INSTR};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign valid_o = ifid_q.valid;
    assign pc_o    = ifid_q.pc;
    assign pc4_o   = ifid_q.pc4;
    assign instr_o = ifid_q.instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, skid buffer and redirect handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        fetch_fault_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic         drop_q, drop_d;
    logic         fault_q, fault_d;

    logic         outstanding_s;
    logic         req_s;
    logic [31:0]  addr_s;
    logic         load_s;
    logic [31:0]  load_instr_s;

    // A response is owed either while waiting normally or while a squashed one is still in flight.
    assign outstanding_s = (state_q == ST_WAIT) || drop_q;

    // State, PC, skid buffer, drop flag and fault register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0000_0000;
            drop_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic; any redirect overrides stall and the current state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        drop_d  = drop_q;
        fault_d = fault_q;
        if (redirect_i) begin
            buf_d  = 32'h0000_0000;
            drop_d = outstanding_s && !imem_rvalid_i;
            if (redirect_pc_i[1:0] != 2'b00) begin
                state_d = ST_HALT;
                fault_d = 1'b1;
            end else begin
                pc_d    = redirect_pc_i;
                fault_d = 1'b0;
                state_d = drop_d ? ST_DRAIN : ST_FETCH;
            end
        end else begin
            if (load_s) begin
                pc_d = pc_inc(pc_q);
            end else begin
                pc_d = pc_q;
            end
            case (state_q)
                ST_FETCH: begin
                    if (req_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i && stall_i) begin
                        buf_d   = imem_rdata_i;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid_i) begin
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    if (imem_rvalid_i) begin
                        drop_d = 1'b0;
                    end else begin
                        drop_d = drop_q;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // Request strobe and IF/ID load; no request is ever issued in reset or in a redirect cycle.
    always_comb begin
        req_s        = 1'b0;
        addr_s       = pc_q;
        load_s       = 1'b0;
        load_instr_s = buf_q;
        if (!rst || redirect_i) begin
            req_s = 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    req_s = !stall_i;
                end
                ST_WAIT: begin
                    if (imem_rvalid_i && !stall_i) begin
                        load_s       = 1'b1;
                        load_instr_s = imem_rdata_i;
                        req_s        = 1'b1;
                        addr_s       = pc_inc(pc_q);
                    end else begin
                        load_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    load_s = !stall_i;
                end
                default: begin
                    req_s = 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_s;
    assign imem_addr_o   = addr_s;
    assign fetch_fault_o = fault_q;

    fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .pc_i    (pc_q),
        .pc4_i   (pc_inc(pc_q)),
        .instr_i (load_instr_s),
        .valid_o (ifid_valid_o),
        .pc_o    (ifid_pc_o),
        .pc4_o   (ifid_pc4_o),
        .instr_o (ifid_instr_o)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage for the pipelined RV32I core.
- Owns the PC and drives a request/response instruction-memory port with one request outstanding at a time.
- Produces the IF/ID pipeline register (valid, PC, PC+4, instruction) consumed by decode.
- Accepts stall and flush from the hazard unit, and PC redirects from the execute stage (taken branch, JAL, JALR).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID when invalid

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
stall_i  input  1  hold IF/ID and stop issuing fetches
flush_i  input  1  squash IF/ID contents at next edge
redirect_i  input  1  load new PC
redirect_pc_i  input  32  redirect target
imem_req_o  output  1  fetch request strobe, one cycle per request
imem_addr_o  output  32  byte address of request
imem_rvalid_i  input  1  response valid
imem_rdata_i  input  32  response instruction word
ifid_valid_o  output  1  IF/ID holds a live instruction
ifid_pc_o  output  32  PC of IF/ID instruction
ifid_pc4_o  output  32  PC+4 of IF/ID instruction
ifid_instr_o  output  32  instruction word
fetch_fault_o  output  1  misaligned redirect fault, level signal

Behaviour:
- Clock and reset: one clock domain, clk; rst is asynchronous and active-low.
- Reset (rst=0), effective immediately:
  - pc=RESET_PC, state=FETCH.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=0, ifid_instr_o=NOP_INSTR.
  - fetch_fault_o=0, drop flag=0, buffer cleared.
  - imem_req_o=0 while rst=0.
- Memory protocol:
  - A request is accepted in the cycle imem_req_o=1.
  - The response arrives at least 1 cycle later.
  - imem_rvalid_i is ignored unless a request is outstanding.
  - imem_req_o and imem_addr_o are combinational from state, pc and inputs.
- FETCH:
  - If stall_i=0: imem_req_o=1, imem_addr_o=pc, go to WAIT.
  - If stall_i=1: no request, stay in FETCH.
- WAIT, on imem_rvalid_i=1:
  - stall_i=0: IF/ID <= {1, pc, pc+4, rdata}; pc <= pc+4.
  - stall_i=0, same cycle: issue the next request with imem_addr_o=pc+4 and stay in WAIT. Throughput is 1 instruction/cycle with a 1-cycle memory.
  - stall_i=1: capture rdata into the skid buffer, go to HOLD, issue no request.
- HOLD:
  - When stall_i=0: IF/ID <= buffer, pc <= pc+4, go to FETCH.
- Redirect (priority over stall_i, all states):
  - pc <= redirect_pc_i and the buffer is discarded.
  - If a request is outstanding and its response is not in this cycle, set the drop flag and go to DRAIN. Otherwise go to FETCH.
  - No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
- DRAIN:
  - The next imem_rvalid_i is discarded, the drop flag is cleared, go to FETCH.
  - A further redirect in DRAIN updates pc and stays in DRAIN.
- Misaligned redirect (redirect_pc_i[1:0]!=0):
  - Go to HALT and set fetch_fault_o=1. pc is not changed.
  - If a request is outstanding, the drop flag is still honoured: its response is discarded on arrival.
  - In HALT no requests are issued.
  - Only an aligned redirect exits HALT: it clears fetch_fault_o and goes to FETCH (DRAIN if the drop flag is still set).
- IF/ID register:
  - flush_i=1: ifid_valid_o <= 0 and ifid_instr_o <= NOP_INSTR. ifid_pc_o and ifid_pc4_o keep their previous values.
  - flush_i has priority over stall_i and over a same-cycle load.
  - stall_i=1 without flush: IF/ID holds.
  - Otherwise, with no load this cycle: ifid_valid_o <= 0 (bubble).
- PC arithmetic:
  - 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
  - ifid_pc4_o is computed from the stored pc, never from redirect_pc_i.

Decomposition:
- Shared constants go in defines.v:
  - FSM state encoding: FETCH, WAIT, HOLD, DRAIN, HALT (3 bits).
  - NOP_INSTR value.
  - RESET_PC default.
- Sub-module if_id_reg:
  - 97-bit register (valid + PC + PC+4 + instruction) with load, hold and flush.
  - Asynchronous active-low reset to the values above.
- The FSM, pc register and skid buffer live in fetch_stage.

Test Plan:
- Reset, 1-cycle memory returning mem[addr]=addr^32'hA5A5_0000 -> requests to 0,4,8 on consecutive cycles; IF/ID pc 0,4,8 with instr 32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008; ifid_valid_o=1 from cycle 2.
- stall_i=1 for 3 cycles while the response for pc=8 arrives -> no imem_req_o during the stall; IF/ID holds pc=4; after release IF/ID pc=8; next request addr=12.
- redirect_i=1 to 32'h100 with a 3-cycle-latency response outstanding for pc=12 -> stale response discarded; next request addr=32'h100; IF/ID never shows pc=12.
- flush_i=1 and stall_i=1 in the same cycle -> ifid_valid_o=0, ifid_instr_o=32'h0000_0013.
- Redirect to 32'h102 -> fetch_fault_o=1, no requests for 5 cycles; then redirect to 32'h200 -> fault clears, request addr=32'h200.
- rst low mid-WAIT -> outputs immediately at reset values; after rst high, first request addr=RESET_PC; the late response is ignored.
